axi4lite_master_arbiter: RTL and testbench

//  Shares one AXI4-Lite master port between NUM_REQ simple request ports (CPU/debug/DMA-style clients).

---
 rtl/axi4lite_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/axi4lite_master_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_axi4lite_master_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite master arbiter.
package axi4lite_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WR_RESP,
      READ,
      RD_DATA
   } arb_state_t;

   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_SLVERR  = 2'b10;
   localparam logic [1:0] RESP_DECERR  = 2'b11;
   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   // Width of an index into n requesters (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i wins.
module rr_arbiter
   import axi4lite_arb_pkg::*;
#(
   parameter int unsigned N    = 2,
   parameter int unsigned IdxW = idx_width(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            valid_o
);

   int unsigned       pos;
   logic [IdxW-1:0]   cand;

   // Scan requesters starting at the pointer, wrapping once.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      pos     = 0;
      cand    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = 32'(ptr_i) + k;
         if (pos >= N) pos = pos - N;
         cand = IdxW'(pos);
         if (!valid_o && req_i[cand]) begin
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi4lite_master_arbiter.sv
// Round-robin sharing of one AXI4-Lite master port among NUM_REQ clients,
// one outstanding transaction at a time.
module axi4lite_master_arbiter
   import axi4lite_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic [1:0]                    rsp_resp,
   output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
   output logic [2:0]                    m_axi_awprot,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [DATA_WIDTH-1:0]         m_axi_wdata,
   output logic [STRB_WIDTH-1:0]         m_axi_wstrb,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
   output logic [2:0]                    m_axi_arprot,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready
);

   localparam int unsigned IdxW = idx_width(NUM_REQ);

   arb_state_t              state_q, state_d;
   logic [IdxW-1:0]         ptr_q, ptr_d;
   logic [IdxW-1:0]         gnt_idx_q, gnt_idx_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]              rsp_resp_q, rsp_resp_d;

   logic [NUM_REQ-1:0]      arb_gnt;
   logic [IdxW-1:0]         arb_idx;
   logic                    arb_valid;
   logic                    grant_en;

   rr_arbiter #(
      .N    (NUM_REQ),
      .IdxW (IdxW)
   ) u_rr_arbiter (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // Hold off re-grant during the rsp_valid cycle so responses never overlap a grant.
   assign grant_en  = (state_q == IDLE) && arb_valid && !(|rsp_valid_q);
   // Gated by reset so a client holding req_valid never sees a grant while in reset.
   assign req_ready = (grant_en && ARESETN) ? arb_gnt : '0;

   // Next-state: arbitration, AXI channel sequencing and response capture.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_idx_d   = gnt_idx_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      unique case (state_q)
         IDLE: begin
            if (grant_en) begin
               gnt_idx_d = arb_idx;
               ptr_d     = (arb_idx == IdxW'(NUM_REQ - 1)) ? '0 : arb_idx + IdxW'(1);
               addr_d    = req_addr[32'(arb_idx) * ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d   = req_wdata[32'(arb_idx) * DATA_WIDTH +: DATA_WIDTH];
               wstrb_d   = req_wstrb[32'(arb_idx) * STRB_WIDTH +: STRB_WIDTH];
               if (req_write[arb_idx]) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WRITE;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = READ;
               end
            end
         end
         WRITE: begin
            // AW and W retire independently; move on once both have handshaken.
            if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (m_axi_bvalid) begin
               bready_d               = 1'b0;
               rsp_valid_d[gnt_idx_q] = 1'b1;
               rsp_resp_d             = m_axi_bresp;
               rsp_rdata_d            = '0;
               state_d                = IDLE;
            end
         end
         READ: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (m_axi_rvalid) begin
               rready_d               = 1'b0;
               rsp_valid_d[gnt_idx_q] = 1'b1;
               rsp_rdata_d            = m_axi_rdata;
               rsp_resp_d             = m_axi_rresp;
               state_d                = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_idx_q   <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= RESP_OKAY;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_idx_q   <= gnt_idx_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = PROT_DEFAULT;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = PROT_DEFAULT;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// Directed bench for axi4lite_master_arbiter with a small programmable slave.
module tb_axi4lite_master_arbiter;

   localparam int unsigned NR = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   logic             ACLK = 1'b0;
   logic             ARESETN = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR-1:0]    req_write = '0;
   logic [NR*AW-1:0] req_addr  = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR*SW-1:0] req_wstrb = '0;
   logic [NR-1:0]    req_ready, rsp_valid;
   logic [DW-1:0]    rsp_rdata;
   logic [1:0]       rsp_resp;
   logic [AW-1:0]    m_axi_awaddr, m_axi_araddr;
   logic [2:0]       m_axi_awprot, m_axi_arprot;
   logic             m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
   logic [DW-1:0]    m_axi_wdata;
   logic [SW-1:0]    m_axi_wstrb;
   logic             m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
   logic             m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
   logic [1:0]       m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
   logic [DW-1:0]    m_axi_rdata = '0;

   // Slave knobs
   int         aw_delay = 0, w_delay = 0, ar_delay = 0;
   logic [1:0] bresp_val = 2'b00, rresp_val = 2'b00;
   logic [31:0] rdata_val = '0;
   bit         r_hold = 1'b0;

   int n_vec = 0, n_err = 0;
   int rsp_cnt = 0, outstanding = 0, max_out = 0, cyc = 0, grant_cyc = 0, rsp_cyc = 0;
   int grants[$];

   always #5 ACLK = ~ACLK;

   axi4lite_master_arbiter #(
      .NUM_REQ    (NR),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .STRB_WIDTH (SW)
   ) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .req_valid     (req_valid),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_wstrb     (req_wstrb),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_resp      (rsp_resp),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awprot  (m_axi_awprot),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Slave: READY rises after VALID has been high for the programmed number of cycles.
   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
   initial begin
      forever begin
         @(negedge ACLK);
         if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= aw_delay); aw_cnt++; end
         else begin m_axi_awready = 1'b0; aw_cnt = 0; end
         if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= w_delay); w_cnt++; end
         else begin m_axi_wready = 1'b0; w_cnt = 0; end
         if (m_axi_arvalid) begin m_axi_arready = (ar_cnt >= ar_delay); ar_cnt++; end
         else begin m_axi_arready = 1'b0; ar_cnt = 0; end
         m_axi_bvalid = m_axi_bready;
         m_axi_bresp  = bresp_val;
         m_axi_rvalid = m_axi_rready && !r_hold;
         m_axi_rdata  = rdata_val;
         m_axi_rresp  = rresp_val;
      end
   end

   // Monitor: grant order, response count and outstanding depth.
   initial begin
      forever begin
         @(negedge ACLK);
         #2;
         cyc++;
         if (!ARESETN) outstanding = 0;
         if (|req_ready) begin
            for (int i = 0; i < NR; i++) if (req_ready[i]) grants.push_back(i);
            grant_cyc = cyc;
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
         end
         if (|rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            outstanding--;
         end
      end
   end

   // Call at a negedge; returns one cycle after the grant edge with req_valid dropped.
   task automatic request(input int c, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, output int waits);
      req_write[c]          = wr;
      req_addr[c*AW +: AW]  = addr;
      req_wdata[c*DW +: DW] = data;
      req_wstrb[c*SW +: SW] = strb;
      req_valid[c]          = 1'b1;
      waits = 0;
      #1;
      while (!req_ready[c] && waits < 30) begin
         @(negedge ACLK);
         #1;
         waits++;
      end
      if (!req_ready[c]) check_eq("grant_timeout", 64'(req_ready[c]), 64'd1);
      @(posedge ACLK);
      #1;
      req_valid[c] = 1'b0;
   endtask

   task automatic wait_rsp(output logic [1:0] v, output logic [31:0] rd, output logic [1:0] rs);
      int n;
      n = 0;
      @(negedge ACLK);
      #1;
      while (!(|rsp_valid) && n < 40) begin
         @(negedge ACLK);
         #1;
         n++;
      end
      if (!(|rsp_valid)) check_eq("rsp_timeout", 64'(rsp_valid), 64'd1);
      v  = rsp_valid;
      rd = rsp_rdata;
      rs = rsp_resp;
   endtask

   initial begin
      int w, n, base;
      bit stable;
      logic [1:0] v, rs;
      logic [31:0] rd;

      // Reset state
      #12;
      check_eq("rst_ctrl", 64'({req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid,
                                m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
      check_eq("rst_rsp", 64'({rsp_rdata, rsp_resp}), 64'd0);
      check_eq("rst_addr", 64'({m_axi_awaddr, m_axi_wstrb}), 64'd0);
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);

      // 1: zero-wait write from client 0
      request(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, w);
      check_eq("t1_grant_wait", 64'(w), 64'd0);
      @(negedge ACLK); #1;
      check_eq("t1_aw_w_together", 64'({m_axi_awvalid, m_axi_wvalid}), 64'b11);
      check_eq("t1_awaddr", 64'(m_axi_awaddr), 64'h10);
      check_eq("t1_wdata_strb", 64'({m_axi_wdata, m_axi_wstrb}), 64'hDEADBEEF_F);
      check_eq("t1_prot", 64'({m_axi_awprot, m_axi_arprot}), 64'd0);
      @(negedge ACLK); #1;
      check_eq("t1_bready", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'b001);
      @(negedge ACLK); #1;
      check_eq("t1_rsp_valid", 64'(rsp_valid), 64'b01);
      check_eq("t1_rsp", 64'({rsp_rdata, rsp_resp}), 64'd0);
      @(negedge ACLK);
      check_eq("t1_latency", 64'(rsp_cyc - grant_cyc), 64'd3);

      // 2: read from client 1, ARREADY delayed 3 cycles
      ar_delay  = 3;
      rdata_val = 32'h12345678;
      request(1, 1'b0, 32'h20, 32'h0, 4'h0, w);
      n = 0;
      stable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge ACLK); #1;
         if (m_axi_arvalid) begin
            n++;
            if (m_axi_araddr != 32'h20) stable = 1'b0;
         end else if (n > 0) break;
      end
      check_eq("t2_ar_cycles", 64'(n), 64'd4);
      check_eq("t2_araddr_stable", 64'(stable), 64'd1);
      wait_rsp(v, rd, rs);
      check_eq("t2_rsp_valid", 64'(v), 64'b10);
      check_eq("t2_rdata", 64'(rd), 64'h12345678);
      check_eq("t2_rresp", 64'(rs), 64'd0);
      ar_delay = 0;

      // 3: both clients request continuously, four writes
      @(negedge ACLK);
      grants.delete();
      max_out = 0;
      req_write = 2'b11;
      req_addr  = {32'h104, 32'h100};
      req_wdata = {32'hBBBB0001, 32'hAAAA0000};
      req_wstrb = 8'hFF;
      req_valid = 2'b11;
      n = 0;
      for (int i = 0; i < 60 && n < 4; i++) begin
         @(negedge ACLK); #1;
         if (|rsp_valid) n++;
      end
      req_valid = 2'b00;
      check_eq("t3_rsp_count", 64'(n), 64'd4);
      repeat (3) @(negedge ACLK);
      check_eq("t3_grant_count", 64'(grants.size()), 64'd4);
      for (int i = 0; i < 4 && i < grants.size(); i++)
         check_eq($sformatf("t3_grant%0d", i), 64'(grants[i]), 64'(i % 2));
      check_eq("t3_max_outstanding", 64'(max_out), 64'd1);

      // 4: W handshakes two cycles before AW
      aw_delay = 2;
      base = rsp_cnt;
      request(0, 1'b1, 32'h30, 32'h0BADF00D, 4'h3, w);
      @(negedge ACLK); #1;
      check_eq("t4_t1_both", 64'({m_axi_awvalid, m_axi_wvalid}), 64'b11);
      @(negedge ACLK); #1;
      check_eq("t4_t2_w_dropped", 64'({m_axi_awvalid, m_axi_wvalid}), 64'b10);
      @(negedge ACLK); #1;
      check_eq("t4_t3_aw_held", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_awaddr}), {2'b10, 32'h30});
      @(negedge ACLK); #1;
      check_eq("t4_t4_bready", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'b001);
      @(negedge ACLK); #1;
      check_eq("t4_rsp_valid", 64'(rsp_valid), 64'b01);
      repeat (3) @(negedge ACLK);
      check_eq("t4_one_rsp", 64'(rsp_cnt - base), 64'd1);
      aw_delay = 0;

      // 5: SLVERR passes through, next transaction is normal
      bresp_val = 2'b10;
      request(1, 1'b1, 32'h50, 32'h5, 4'h1, w);
      wait_rsp(v, rd, rs);
      check_eq("t5_err_rsp", 64'({v, rs}), 64'b10_10);
      bresp_val = 2'b00;
      rdata_val = 32'hCAFEF00D;
      @(negedge ACLK);
      request(0, 1'b0, 32'h54, 32'h0, 4'h0, w);
      check_eq("t5_next_grant_wait", 64'(w), 64'd0);
      wait_rsp(v, rd, rs);
      check_eq("t5_next_rsp", 64'({v, rs, rd}), {2'b01, 2'b00, 32'hCAFEF00D});

      // 6: reset while waiting in RD_DATA
      r_hold = 1'b1;
      @(negedge ACLK);
      request(0, 1'b0, 32'h40, 32'h0, 4'h0, w);
      for (int i = 0; i < 10 && !m_axi_rready; i++) begin
         @(negedge ACLK); #1;
      end
      check_eq("t6_in_rd_data", 64'(m_axi_rready), 64'd1);
      base = rsp_cnt;
      ARESETN   = 1'b0;
      req_write = 2'b00;
      req_valid = 2'b11;
      #1;
      check_eq("t6_rst_ctrl", 64'({req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid,
                                   m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
      check_eq("t6_rst_rsp", 64'({rsp_rdata, rsp_resp}), 64'd0);
      check_eq("t6_rst_addr", 64'(m_axi_araddr), 64'd0);
      repeat (3) @(negedge ACLK);
      r_hold = 1'b0;
      check_eq("t6_no_rsp", 64'(rsp_cnt - base), 64'd0);
      ARESETN = 1'b1;
      #1;
      check_eq("t6_post_rst_grant", 64'(req_ready), 64'b01);
      @(posedge ACLK); #1;
      req_valid = 2'b00;
      wait_rsp(v, rd, rs);
      check_eq("t6_post_rst_rsp", 64'(v), 64'b01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
